// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared state encoding and default geometry for the register-file access controller
package mem_ctrl_pkg;
  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 3;
  localparam int DEPTH_DEF = 1 << ADDR_W_DEF;
  typedef enum logic [2:0] {IDLE, WRITE, READ, VERIFY, RESP} state_t;
endpackage

// File: rtl/mem_addr_decoder.sv
// mem_addr_decoder: gated address to one-hot row-enable decoder (registered by parent)
module mem_addr_decoder
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              en,
  output logic [DEPTH-1:0]  onehot
);
  assign onehot = en ? DEPTH'(1) << addr : '0;
endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: one-at-a-time request sequencer for the 8x8 register file; WR_VERIFY_EN adds a post-write re-read check
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  localparam int DEPTH = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic [DEPTH-1:0]  mem_en,
  output logic              mem_rd_bar,
  output logic              mem_wr_bar,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);
`ifdef WR_VERIFY_EN
  localparam state_t AFTER_WR = VERIFY;
`else
  localparam state_t AFTER_WR = RESP;
`endif
  state_t state, nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0] en_dec;
  logic xfer;
  logic strobe_nxt;
  assign xfer = req_valid & req_ready;
  // next state: accept in IDLE, single strobe cycle(s), hold RESP until consumed
  always_comb begin
    nxt = (state == IDLE)   ? (xfer ? (req_we ? WRITE : READ) : IDLE) :
          (state == WRITE)  ? AFTER_WR :
          (state == READ || state == VERIFY) ? RESP :
          (state == RESP && !rsp_ready) ? RESP : IDLE;
  end
  assign strobe_nxt = (nxt == WRITE) || (nxt == READ) || (nxt == VERIFY);
  mem_addr_decoder #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec (
    .addr   (state == IDLE ? req_addr : addr_q),
    .en     (strobe_nxt),
    .onehot (en_dec)
  );
  // state and all outputs registered from the next state so strobes never glitch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr_q     <= '0;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      mem_en     <= '0;
      mem_rd_bar <= 1'b1;
      mem_wr_bar <= 1'b1;
      mem_wdata  <= '0;
    end else begin
      state      <= nxt;
      req_ready  <= nxt == IDLE;
      rsp_valid  <= nxt == RESP;
      mem_en     <= en_dec;
      mem_rd_bar <= !(nxt == READ || nxt == VERIFY);
      mem_wr_bar <= nxt != WRITE;
      if (xfer) begin
        addr_q    <= req_addr;
        mem_wdata <= req_wdata;
        rsp_rdata <= '0;
      end else if (state == READ) begin
        rsp_rdata <= mem_rdata;
      end
    end
  end
`ifdef WR_VERIFY_EN
  // verify result: cleared on accept, set from the re-read row in VERIFY
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rsp_err <= 1'b0;
    else rsp_err <= xfer ? 1'b0 : (state == VERIFY) ? (mem_rdata != mem_wdata) : rsp_err;
  end
`else
  assign rsp_err = 1'b0;
`endif
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: table-driven + scoreboard bench for mem_access_ctrl with a behavioural 8x8 row model
module tb_mem_access_ctrl;
`ifdef WR_VERIFY_EN
  localparam bit VER = 1'b1;
`else
  localparam bit VER = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_valid = 1'b0;
  logic req_ready;
  logic req_we = 1'b0;
  logic [2:0] req_addr = '0;
  logic [7:0] req_wdata = '0;
  logic rsp_valid;
  logic rsp_ready = 1'b1;
  logic [7:0] rsp_rdata;
  logic rsp_err;
  logic [7:0] mem_en;
  logic mem_rd_bar;
  logic mem_wr_bar;
  logic [7:0] mem_wdata;
  logic [7:0] mem_rdata;
  logic [7:0] rows [8];
  logic stuck = 1'b0;
  logic [8:0] exp_q [$];
  int checks = 0;
  int failures = 0;

  typedef struct {
    logic       we;
    logic [2:0] addr;
    logic [7:0] wdata;
    logic [7:0] exp_rdata;
    logic       exp_err;
  } vec_t;
  vec_t vecs [18];

  always #5 clk = ~clk;

  mem_access_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_en(mem_en), .mem_rd_bar(mem_rd_bar), .mem_wr_bar(mem_wr_bar),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always @(posedge clk)
    if (!mem_wr_bar)
      for (int i = 0; i < 8; i++)
        if (mem_en[i]) rows[i] <= stuck ? {mem_wdata[7:1], 1'b0} : mem_wdata;

  always_comb begin
    mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      if (mem_en[i]) mem_rdata = mem_rdata | rows[i];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) chk("rsp_unexpected", 1, 0);
      else begin
        logic [8:0] e;
        e = exp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, e[8:1]);
        chk("rsp_err", rsp_err, e[0]);
      end
    end
    if (!mem_rd_bar || !mem_wr_bar) begin
      chk("strobes_exclusive", !mem_rd_bar && !mem_wr_bar, 0);
      chk("en_onehot", $onehot(mem_en), 1);
    end else if (mem_en != 0) chk("en_idle_zero", mem_en, 0);
  end

  task automatic issue(input logic we, input logic [2:0] a, input logic [7:0] d,
                       input logic [7:0] er, input logic ee);
    int n = 0;
    req_we = we; req_addr = a; req_wdata = d; req_valid = 1'b1;
    exp_q.push_back({er, ee});
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    chk("accept", req_ready, 1);
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("t1_en", mem_en, 8'(1) << a);
    chk("t1_wr_bar", mem_wr_bar, !we);
    chk("t1_rd_bar", mem_rd_bar, we);
    if (we) chk("t1_wdata", mem_wdata, d);
    @(negedge clk);
    if (we && VER) begin
      chk("vfy_rd_bar", mem_rd_bar, 0);
      chk("vfy_en", mem_en, 8'(1) << a);
      chk("vfy_no_valid", rsp_valid, 0);
      @(negedge clk);
    end
    chk("latency_valid", rsp_valid, 1);
  endtask

  task automatic wait_rsp();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin @(posedge clk); n++; end
    chk("rsp_done", exp_q.size(), 0);
    #1;
  endtask

  initial begin
    vecs[0] = '{1'b1, 3'd3, 8'hA5, 8'h00, 1'b0};
    vecs[1] = '{1'b0, 3'd3, 8'h00, 8'hA5, 1'b0};
    for (int i = 0; i < 8; i++) begin
      vecs[2 + i]  = '{1'b1, 3'(i), 8'(i) ^ 8'h5A, 8'h00, 1'b0};
      vecs[10 + i] = '{1'b0, 3'(i), 8'h00, 8'(i) ^ 8'h5A, 1'b0};
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_mem_en", mem_en, 0);
    chk("rst_rd_bar", mem_rd_bar, 1);
    chk("rst_wr_bar", mem_wr_bar, 1);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 0; i < 18; i++) begin
      issue(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rdata, vecs[i].exp_err);
      wait_rsp();
    end
    // backpressure with a second request held upstream
    rsp_ready = 1'b0;
    issue(1'b0, 3'd3, 8'h00, 8'h59, 1'b0);
    req_we = 1'b1; req_addr = 3'd5; req_wdata = 8'h33; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", rsp_valid, 1);
      chk("bp_rdata", rsp_rdata, 8'h59);
      chk("bp_req_ready", req_ready, 0);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    issue(1'b1, 3'd5, 8'h33, 8'h00, 1'b0);
    wait_rsp();
    issue(1'b0, 3'd5, 8'h00, 8'h33, 1'b0);
    wait_rsp();
    // reset in the middle of a read
    req_we = 1'b0; req_addr = 3'd6; req_valid = 1'b1;
    begin
      int n = 0;
      @(negedge clk);
      while (!req_ready && n < 20) begin @(negedge clk); n++; end
    end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    chk("mid_rd_bar_low", mem_rd_bar, 0);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_rd_bar", mem_rd_bar, 1);
    chk("mid_rst_wr_bar", mem_wr_bar, 1);
    chk("mid_rst_en", mem_en, 0);
    chk("mid_rst_valid", rsp_valid, 0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", req_ready, 1);
    chk("post_rst_valid", rsp_valid, 0);
    if (VER) begin
      stuck = 1'b1;
      issue(1'b1, 3'd2, 8'h01, 8'h00, 1'b1);
      wait_rsp();
      issue(1'b1, 3'd4, 8'h02, 8'h00, 1'b0);
      wait_rsp();
      stuck = 1'b0;
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
